// File: rtl/fm_scan_ctrl.sv
// FM channel scanner: tunes scan_count channels from freq_base, reads each RSSI, keeps the strongest.
// Define FM_SCAN_TIMEOUT_EN to add a MEASURE watchdog (sticky timeout_err, timed-out channel skipped).
module fm_scan_ctrl #(
  parameter int FREQ_WIDTH     = 16,
  parameter int CNT_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 256,
  parameter int CLEAR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int FM_ADDR_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     scan_start,
  input  logic                     scan_abort,
  input  logic [FREQ_WIDTH-1:0]    freq_base,
  input  logic [FREQ_WIDTH-1:0]    freq_step,
  input  logic [CNT_WIDTH-1:0]     scan_count,
  input  logic                     tune_ack,
  input  logic                     RSSI_interrupt,
  input  logic [31:0]              rdata,
  output logic                     tune_req,
  output logic [FREQ_WIDTH-1:0]    tune_freq,
  output logic [3:0]               FM_HW_state,
  output logic [FM_ADDR_WIDTH-1:0] rdaddr,
  output logic                     busy,
  output logic                     scan_done,
  output logic [CNT_WIDTH-1:0]     best_idx,
  output logic [FREQ_WIDTH-1:0]    best_freq,
  output logic [16:0]              best_rssi,
  output logic                     best_valid,
  output logic                     timeout_err
);

  localparam int CNT_A   = (SETTLE_CYCLES > CLEAR_CYCLES) ? SETTLE_CYCLES : CLEAR_CYCLES;
  localparam int CNT_MAX = (CNT_A > 2) ? CNT_A : 2;
  localparam int TW      = $clog2(CNT_MAX + 1);
  localparam logic [FM_ADDR_WIDTH-1:0] RSSI_ADDR = FM_ADDR_WIDTH'(20);

  typedef enum logic [2:0] {
    S_IDLE, S_TUNE, S_SETTLE, S_MEASURE, S_READ, S_CLEAR, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TW-1:0]         r_cnt;
  logic                  r_abort;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [FREQ_WIDTH-1:0] r_freq;
  logic [CNT_WIDTH-1:0]  r_best_idx;
  logic [FREQ_WIDTH-1:0] r_best_freq;
  logic [16:0]           r_best_rssi;
  logic                  r_best_valid;

  logic        w_start;
  logic        w_abort;
  logic        w_last;
  logic        w_settle_done;
  logic        w_read_last;
  logic        w_clear_done;
  logic        w_timeout;
  logic [16:0] w_rssi;
  logic        w_unused_rdata;

  assign w_start        = scan_start && (r_state == S_IDLE);
  assign w_abort        = scan_abort && (r_state inside {S_TUNE, S_SETTLE, S_MEASURE, S_READ, S_NEXT});
  assign w_last         = (r_idx == r_count - CNT_WIDTH'(1));
  assign w_settle_done  = (r_cnt == TW'(SETTLE_CYCLES - 1));
  assign w_read_last    = (r_cnt == TW'(1));
  assign w_clear_done   = (r_cnt == TW'(CLEAR_CYCLES - 1));
  assign w_rssi         = rdata[16:0];
  assign w_unused_rdata = ^rdata[31:17];

`ifdef FM_SCAN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_timeout_err;

  assign w_timeout   = (r_state == S_MEASURE) && !RSSI_interrupt && (r_wd == WW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd <= (r_state == S_MEASURE && w_next == S_MEASURE) ? r_wd + WW'(1) : '0;
      if (w_start)
        r_timeout_err <= 1'b0;
      else if (w_timeout && !w_abort)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (scan_start) w_next = (scan_count != '0) ? S_TUNE : S_DONE;
      S_TUNE:    if (w_abort) w_next = S_CLEAR; else if (tune_ack) w_next = S_SETTLE;
      S_SETTLE:  if (w_abort) w_next = S_CLEAR; else if (w_settle_done) w_next = S_MEASURE;
      S_MEASURE: begin
        if (w_abort)             w_next = S_CLEAR;
        else if (RSSI_interrupt) w_next = S_READ;
        else if (w_timeout)      w_next = S_CLEAR;
      end
      S_READ:    if (w_abort || w_read_last) w_next = S_CLEAR;
      // An aborted scan leaves through CLEAR straight back to IDLE.
      S_CLEAR:   if (w_clear_done) w_next = r_abort ? S_IDLE : S_NEXT;
      S_NEXT:    if (w_abort) w_next = S_CLEAR; else w_next = w_last ? S_DONE : S_TUNE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tune_req    = 1'b0;
    busy        = 1'b1;
    scan_done   = 1'b0;
    FM_HW_state = 4'b0000;
    rdaddr      = '0;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_TUNE:    tune_req = 1'b1;
      S_MEASURE: FM_HW_state = 4'b0100;
      S_READ: begin
        FM_HW_state = 4'b0100;
        rdaddr      = RSSI_ADDR;
      end
      S_CLEAR:   FM_HW_state = 4'b1000;
      S_DONE:    scan_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_idx        <= '0;
      r_count      <= '0;
      r_freq       <= '0;
      r_best_idx   <= '0;
      r_best_freq  <= '0;
      r_best_rssi  <= '0;
      r_best_valid <= 1'b0;
    end else begin
      if (w_next != r_state || !(r_state inside {S_SETTLE, S_READ, S_CLEAR}))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + TW'(1);

      if (w_abort)
        r_abort <= 1'b1;
      else if (r_state == S_CLEAR && w_clear_done)
        r_abort <= 1'b0;

      if (w_start) begin
        r_idx        <= '0;
        r_count      <= scan_count;
        r_best_idx   <= '0;
        r_best_freq  <= '0;
        r_best_rssi  <= '0;
        r_best_valid <= 1'b0;
        if (scan_count != '0)
          r_freq <= freq_base;
      end else if (r_state == S_NEXT && w_next == S_TUNE) begin
        r_idx  <= r_idx + CNT_WIDTH'(1);
        r_freq <= r_freq + freq_step;
      end

      // Strict compare so that equal readings keep the earlier channel.
      if (r_state == S_READ && w_read_last && !w_abort &&
          (!r_best_valid || w_rssi > r_best_rssi)) begin
        r_best_idx   <= r_idx;
        r_best_freq  <= r_freq;
        r_best_rssi  <= w_rssi;
        r_best_valid <= 1'b1;
      end
    end
  end

  assign tune_freq  = r_freq;
  assign best_idx   = r_best_idx;
  assign best_freq  = r_best_freq;
  assign best_rssi  = r_best_rssi;
  assign best_valid = r_best_valid;

endmodule

// File: tb/tb_fm_scan_ctrl.sv
// Directed bench for fm_scan_ctrl with a registered RSSI read-port model.
module tb_fm_scan_ctrl;
  localparam int FW = 16, CW = 8, AW = 6, SETTLE = 8, CLR = 4, TMO = 64;

  logic          clk = 1'b0, RSTn = 1'b0;
  logic          scan_start = 1'b0, scan_abort = 1'b0, tune_ack = 1'b0, RSSI_interrupt = 1'b0;
  logic [FW-1:0] freq_base = '0, freq_step = '0;
  logic [CW-1:0] scan_count = '0;
  logic [31:0]   rdata = '0;
  logic          tune_req, busy, scan_done, best_valid, timeout_err;
  logic [FW-1:0] tune_freq, best_freq;
  logic [3:0]    FM_HW_state;
  logic [AW-1:0] rdaddr;
  logic [CW-1:0] best_idx;
  logic [16:0]   best_rssi;
  logic [16:0]   cur_rssi = '0;
  int tests = 0, fails = 0, done_cnt = 0, done_ref = 0;

  always #5 clk = ~clk;

  fm_scan_ctrl #(.FREQ_WIDTH(FW), .CNT_WIDTH(CW), .SETTLE_CYCLES(SETTLE), .CLEAR_CYCLES(CLR),
                 .TIMEOUT_CYCLES(TMO), .FM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .RSTn(RSTn), .scan_start(scan_start), .scan_abort(scan_abort),
    .freq_base(freq_base), .freq_step(freq_step), .scan_count(scan_count),
    .tune_ack(tune_ack), .RSSI_interrupt(RSSI_interrupt), .rdata(rdata),
    .tune_req(tune_req), .tune_freq(tune_freq), .FM_HW_state(FM_HW_state), .rdaddr(rdaddr),
    .busy(busy), .scan_done(scan_done), .best_idx(best_idx), .best_freq(best_freq),
    .best_rssi(best_rssi), .best_valid(best_valid), .timeout_err(timeout_err)
  );

  // RSSI scanner read port: one-cycle registered latency, junk in the upper bits.
  always @(posedge clk) rdata <= (rdaddr == AW'(20)) ? {15'h2AB5, cur_rssi} : 32'd0;
  always @(negedge clk) if (scan_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_scan(input logic [FW-1:0] b, input logic [FW-1:0] s, input logic [CW-1:0] c);
    done_ref   = done_cnt;
    freq_base  = b;
    freq_step  = s;
    scan_count = c;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic wait_tune(input string nm);
    int n = 0;
    while (tune_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({nm, " tune_req up"}, tune_req, 1'b1);
  endtask

  task automatic do_channel(input string nm, input logic [FW-1:0] exp_freq, input int ack_dly,
                            input logic [16:0] rssi, input bit irq);
    int n, hold;
    wait_tune(nm);
    check({nm, " tune_freq"}, tune_freq, exp_freq);
    hold = 0;
    repeat (ack_dly) begin
      @(negedge clk);
      if (tune_req === 1'b1 && tune_freq === exp_freq) hold++;
    end
    check({nm, " tune_req held"}, hold, ack_dly);
    tune_ack = 1'b1;
    @(negedge clk);
    tune_ack = 1'b0;
    check({nm, " tune_req drop"}, tune_req, 1'b0);
    n = 0;
    while (FM_HW_state !== 4'b0100 && n < 1000) begin @(negedge clk); n++; end
    check({nm, " settle length"}, n, SETTLE);
    if (irq) begin
      cur_rssi = rssi;
      repeat (3) @(negedge clk);
      RSSI_interrupt = 1'b1;
      @(negedge clk);
      RSSI_interrupt = 1'b0;
      check({nm, " read addr"}, {FM_HW_state, rdaddr}, {4'b0100, 6'h14});
      repeat (2) @(negedge clk);
    end else begin
      n = 0;
      while (FM_HW_state !== 4'b1000 && n < 500) begin @(negedge clk); n++; end
    end
    check({nm, " clear entry"}, {FM_HW_state, rdaddr}, {4'b1000, 6'h00});
    n = 0;
    while (FM_HW_state === 4'b1000 && n < 100) begin @(negedge clk); n++; end
    check({nm, " clear length"}, n, CLR);
  endtask

  task automatic finish_scan(input string nm, input logic [CW-1:0] ei, input logic [FW-1:0] ef,
                             input logic [16:0] er, input int ed);
    repeat (4) @(negedge clk);
    check({nm, " busy"}, busy, 1'b0);
    check({nm, " best_idx"}, best_idx, ei);
    check({nm, " best_freq"}, best_freq, ef);
    check({nm, " best_rssi"}, best_rssi, er);
    check({nm, " best_valid"}, best_valid, 1'b1);
    check({nm, " scan_done pulses"}, done_cnt - done_ref, ed);
  endtask

  initial begin
    int n;
    #12;
    check("reset outputs", {tune_req, tune_freq, FM_HW_state, rdaddr, busy, scan_done, best_idx,
                            best_freq, best_rssi, best_valid, timeout_err}, 0);
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);

    // Three channels, strongest in the middle; channel 1 ack is late.
    start_scan(16'h1000, 16'h0010, 8'd3);
    check("A busy", busy, 1'b1);
    do_channel("A0", 16'h1000, 0, 17'd100, 1'b1);
    freq_base  = 16'h7777;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    do_channel("A1", 16'h1010, 10, 17'd300, 1'b1);
    do_channel("A2", 16'h1020, 2, 17'd200, 1'b1);
    finish_scan("A", 8'd1, 16'h1010, 17'd300, 1);

    // Equal readings keep the lower index.
    start_scan(16'h2000, 16'h0100, 8'd2);
    do_channel("B0", 16'h2000, 1, 17'd500, 1'b1);
    do_channel("B1", 16'h2100, 1, 17'd500, 1'b1);
    finish_scan("B", 8'd0, 16'h2000, 17'd500, 1);

    // Zero-length scan completes immediately with nothing measured.
    start_scan(16'h3000, 16'h0001, 8'd0);
    check("C scan_done", scan_done, 1'b1);
    @(negedge clk);
    check("C idle", {busy, scan_done}, 2'b00);
    check("C best_valid", best_valid, 1'b0);
    check("C done pulses", done_cnt - done_ref, 1);

    // Abort during the second MEASURE of four.
    start_scan(16'h4000, 16'h0020, 8'd4);
    do_channel("D0", 16'h4000, 1, 17'd50, 1'b1);
    wait_tune("D1");
    check("D1 tune_freq", tune_freq, 16'h4020);
    tune_ack = 1'b1;
    @(negedge clk);
    tune_ack = 1'b0;
    n = 0;
    while (FM_HW_state !== 4'b0100 && n < 1000) begin @(negedge clk); n++; end
    check("D1 measure", FM_HW_state, 4'b0100);
    cur_rssi = 17'd999;
    repeat (2) @(negedge clk);
    scan_abort = 1'b1;
    @(negedge clk);
    scan_abort = 1'b0;
    n = 0;
    while (FM_HW_state === 4'b1000 && n < 100) begin @(negedge clk); n++; end
    check("D abort clear length", n, CLR);
    check("D idle after abort", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("D no scan_done", done_cnt - done_ref, 0);
    check("D best", {best_idx, best_freq, best_rssi, best_valid}, {8'd0, 16'h4000, 17'd50, 1'b1});

    // Tuning word wraps modulo 2^16.
    start_scan(16'hFFF8, 16'h0010, 8'd2);
    do_channel("E0", 16'hFFF8, 0, 17'd10, 1'b1);
    do_channel("E1", 16'h0008, 0, 17'd20, 1'b1);
    finish_scan("E", 8'd1, 16'h0008, 17'd20, 1);

`ifdef FM_SCAN_TIMEOUT_EN
    start_scan(16'h5000, 16'h0100, 8'd3);
    do_channel("F0", 16'h5000, 0, 17'd40, 1'b1);
    do_channel("F1", 16'h5100, 0, 17'd0, 1'b0);
    check("F timeout_err set", timeout_err, 1'b1);
    do_channel("F2", 16'h5200, 0, 17'd70, 1'b1);
    finish_scan("F", 8'd2, 16'h5200, 17'd70, 1);
    check("F timeout_err sticky", timeout_err, 1'b1);
    start_scan(16'h5500, 16'h0001, 8'd1);
    check("F timeout_err cleared", timeout_err, 1'b0);
    do_channel("F3", 16'h5500, 0, 17'd7, 1'b1);
    finish_scan("F3", 8'd0, 16'h5500, 17'd7, 1);
`else
    check("F timeout_err tied", timeout_err, 1'b0);
`endif

    // Reset asserted in SETTLE, then a clean restart.
    start_scan(16'h6000, 16'h0001, 8'd2);
    wait_tune("G");
    tune_ack = 1'b1;
    @(negedge clk);
    tune_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("G pre-reset", {busy, tune_freq}, {1'b1, 16'h6000});
    #2 RSTn = 1'b0;
    #1;
    check("G reset outputs", {tune_req, tune_freq, FM_HW_state, rdaddr, busy, scan_done, best_idx,
                              best_freq, best_rssi, best_valid, timeout_err}, 0);
    @(negedge clk);
    RSTn = 1'b1;
    repeat (2) @(negedge clk);
    check("G no scan_done", done_cnt - done_ref, 0);
    start_scan(16'h7000, 16'h0001, 8'd1);
    do_channel("G0", 16'h7000, 0, 17'd123, 1'b1);
    finish_scan("G", 8'd0, 16'h7000, 17'd123, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end
endmodule

// File: doc/fm_scan_ctrl.md
FM_SCAN_CTRL -- requirements
Module: fm_scan_ctrl

Interface
REQ-001 SHALL have parameter FREQ_WIDTH, default 16, tuning-word width.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, channel-count and index width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256, clk cycles waited after tune_ack.
REQ-004 SHALL have parameter CLEAR_CYCLES, default 4, clk cycles FM_HW_state holds RSSI_DONE.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1048576, measure watchdog limit.
REQ-006 SHALL have parameter FM_ADDR_WIDTH, default 6, RSSI read-address width.
REQ-007 SHALL have ports, one per line:
- clk  input  1  single clock.
- RSTn  input  1  asynchronous active-low reset.
- scan_start  input  1  one-cycle start pulse.
- scan_abort  input  1  one-cycle abort pulse.
- freq_base  input  FREQ_WIDTH  first tuning word.
- freq_step  input  FREQ_WIDTH  tuning-word increment.
- scan_count  input  CNT_WIDTH  number of channels to measure.
- tune_ack  input  1  tuner has accepted tune_freq.
- RSSI_interrupt  input  1  accumulation-done pulse from the RSSI scanner.
- rdata  input  32  RSSI scanner read data (registered, one-cycle latency).
- tune_req  output  1  request to retune.
- tune_freq  output  FREQ_WIDTH  current tuning word.
- FM_HW_state  output  4  hardware state to the RSSI scanner.
- rdaddr  output  FM_ADDR_WIDTH  RSSI scanner read address.
- busy  output  1  scan in progress.
- scan_done  output  1  one-cycle completion pulse.
- best_idx  output  CNT_WIDTH  index of strongest channel.
- best_freq  output  FREQ_WIDTH  tuning word of strongest channel.
- best_rssi  output  17  RSSI of strongest channel.
- best_valid  output  1  at least one channel measured.
- timeout_err  output  1  sticky watchdog flag.

Function
REQ-008 SHALL sequence states IDLE, TUNE, SETTLE, MEASURE, READ, CLEAR, NEXT, DONE.
REQ-009 IDLE: scan_start with scan_count>0 SHALL load idx=0, tune_freq=freq_base, clear best_*, go to TUNE; with scan_count=0 SHALL go to DONE, best_valid=0.
REQ-010 TUNE SHALL hold tune_req=1 until tune_ack is sampled high, then go to SETTLE; tune_freq SHALL be stable while tune_req=1.
REQ-011 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-012 FM_HW_state SHALL be 4'b0100 in MEASURE and READ, 4'b1000 in CLEAR, 4'b0000 elsewhere.
REQ-013 MEASURE SHALL exit to READ on the cycle after RSSI_interrupt is sampled high.
REQ-014 READ SHALL drive rdaddr=0x14 for 2 cycles and capture rdata[16:0] on the second; rdaddr SHALL be 0 outside READ.
REQ-015 Captured value strictly greater than best_rssi, or first channel, SHALL update best_rssi/best_idx/best_freq and set best_valid; ties SHALL keep the lower index.
REQ-016 CLEAR SHALL last CLEAR_CYCLES cycles, then go to NEXT.
REQ-017 NEXT SHALL, if idx==scan_count-1, go to DONE; else idx+=1, tune_freq+=freq_step (modulo 2^FREQ_WIDTH wrap), go to TUNE.
REQ-018 DONE SHALL pulse scan_done for one cycle and return to IDLE; best_* SHALL hold until next accepted start.
REQ-019 busy SHALL be 1 in every state except IDLE; scan_start while busy SHALL be ignored.
REQ-020 scan_abort in any busy state except CLEAR/DONE SHALL go to CLEAR then IDLE without scan_done; best_* retain partial results; scan_start and scan_abort together in IDLE: start wins.

Reset
REQ-021 RSTn low SHALL asynchronously force IDLE and all outputs to 0 (tune_freq, best_*, timeout_err included); release SHALL be synchronous to clk.
REQ-022 Reset mid-scan SHALL abandon the scan with no scan_done pulse.

Configuration
REQ-023 Macro FM_SCAN_TIMEOUT_EN defined: MEASURE exceeding TIMEOUT_CYCLES SHALL set timeout_err, skip compare, go to CLEAR, continue with NEXT; timeout_err clears on accepted scan_start.
REQ-024 Macro undefined: no watchdog counter; MEASURE waits indefinitely; timeout_err tied 0.

Verification
REQ-025 base=0x1000, step=0x10, count=3, RSSI 100/300/200 -> best_idx=1, best_freq=0x1010, best_rssi=300, one scan_done.
REQ-026 count=2, RSSI 500/500 -> best_idx=0; count=0 -> scan_done within 2 cycles, best_valid=0.
REQ-027 tune_ack delayed 10 cycles -> tune_req high exactly until ack; MEASURE entered SETTLE_CYCLES cycles later.
REQ-028 abort during second MEASURE of count=4 -> CLEAR for CLEAR_CYCLES, IDLE, no scan_done, best from channel 0.
REQ-029 With FM_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=64, no interrupt on channel 1 of 3 -> timeout_err=1, channels 0 and 2 compared, scan_done asserted.
REQ-030 RSTn low during SETTLE -> all outputs 0 same cycle; scan_start after release starts cleanly.
